line_mem_responder: RTL and testbench

- Memory-side responder for the data-cache line-transfer interface: 32-bit address, 256-bit line data, level enable/write request, one-cycle ack.
- Backs each 32-byte line with a 32-bit-wide word SRAM: fixed access latency, then 8 sequential word beats, then ack.
- Drop-in alternative to the behavioural data memory beside the CPU's dcache, with word-level storage for future narrow-bus/DMA masters.

---
 rtl/line_mem_responder.sv | 113 +++++++++++
 tb/tb_line_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - line-transfer memory responder backed by a 32-bit word SRAM
module line_mem_responder #(
    parameter int LINES   = 512,
    parameter int LATENCY = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_ACK
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_line;
    logic               r_write;
    logic [255:0]       r_wdata;
    logic [255:0]       r_shadow;
    logic [255:0]       r_data;
    logic [3:0]         r_wait;
    logic [2:0]         r_beat;
    logic               r_ack;

    logic [31:0]        r_mem [LINES*8];

    logic [IDX_W+2:0]   w_word_addr;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_wr_word;

    assign w_word_addr = {r_line, r_beat};
    assign w_rd_word   = r_mem[w_word_addr];
    assign w_wr_word   = r_wdata[32*r_beat +: 32];

    // Single-port word array: one read or one write per BEAT cycle, never reset.
    always_ff @(posedge clk_i) begin
        if (r_state == S_BEAT && r_write) begin
            r_mem[w_word_addr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_line   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_shadow <= '0;
            r_data   <= '0;
            r_wait   <= '0;
            r_beat   <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_line  <= addr_i[5 +: IDX_W];
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_beat  <= '0;
                        r_wait  <= WAIT_INIT;
                        r_state <= (LATENCY > 0) ? S_WAIT : S_BEAT;
                    end
                end
                S_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_beat  <= '0;
                        r_state <= S_BEAT;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_BEAT: begin
                    if (!r_write) begin
                        r_shadow[32*r_beat +: 32] <= w_rd_word;
                    end
                    if (r_beat == 3'd7) begin
                        // The last word is merged here so data_o is valid in the ACK cycle.
                        if (!r_write) begin
                            r_data <= {w_rd_word, r_shadow[223:0]};
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_beat <= r_beat + 3'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data;
    assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - self-checking bench for line_mem_responder
module tb_line_mem_responder;

    localparam int LAT  = 4;
    localparam int NLIN = 512;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         en;
    logic         wr;
    logic         ack;
    logic [255:0] dout;
    logic         busy;

    logic [31:0]  z_addr;
    logic [255:0] z_din;
    logic         z_en;
    logic         z_wr;
    logic         z_ack;
    logic [255:0] z_dout;
    logic         z_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    line_mem_responder #(.LINES(NLIN), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr), .data_i(din),
        .enable_i(en), .write_i(wr), .ack_o(ack), .data_o(dout), .busy_o(busy)
    );

    line_mem_responder #(.LINES(NLIN), .LATENCY(0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .addr_i(z_addr), .data_i(z_din),
        .enable_i(z_en), .write_i(z_wr), .ack_o(z_ack), .data_o(z_dout), .busy_o(z_busy)
    );

    typedef struct packed {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] d;
        logic [255:0] exp;
    } vec_t;

    vec_t         tv [7];
    logic [255:0] m_line [NLIN];
    bit           m_valid [NLIN];
    logic [255:0] last_rd;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // Caller is positioned 1 time unit after a rising edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d,
                          output logic [255:0] rd, output int lat);
        addr = a; din = d; wr = w; en = 1'b1; lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 200);
        rd = dout;
        en = 1'b0; wr = 1'b0;
        @(posedge clk); #1;
        chk("ack_one_cycle", {255'd0, ack}, 256'd0);
        chk("busy_after_ack", {255'd0, busy}, 256'd0);
    endtask

    task automatic apply(input logic w, input logic [31:0] a, input logic [255:0] d);
        logic [255:0] rd;
        int           lat;
        int           ln;
        ln = int'(a[13:5]);
        do_req(w, a, d, rd, lat);
        chk(w ? "wr_latency" : "rd_latency", lat, LAT + 9);
        if (w) begin
            chk("wr_keeps_data_o", rd, last_rd);
            m_line[ln]  = d;
            m_valid[ln] = 1'b1;
        end else begin
            chk("rd_data", rd, m_line[ln]);
            last_rd = rd;
        end
    endtask

    initial begin
        logic [255:0] pat, dd, r1, zp, rd;
        logic [3:0]   hk;
        int           lat, n;

        for (int k = 0; k < 8; k++) begin
            hk = 4'(k);
            pat[32*k +: 32] = {hk, hk, hk, hk, ~hk, ~hk, ~hk, ~hk};
        end
        dd = {2{128'h0123456789ABCDEFFEDCBA9876543210}};
        for (int i = 0; i < NLIN; i++) m_valid[i] = 1'b0;
        last_rd = '0;

        tv[0] = '{wr: 1'b1, addr: 32'h0000_0000, d: pat, exp: '0};
        tv[1] = '{wr: 1'b0, addr: 32'h0000_0000, d: '0,  exp: pat};
        tv[2] = '{wr: 1'b1, addr: 32'h0000_0220, d: dd,  exp: '0};
        tv[3] = '{wr: 1'b0, addr: 32'h0000_023C, d: '0,  exp: dd};
        tv[4] = '{wr: 1'b0, addr: 32'h0000_4000, d: '0,  exp: pat};
        tv[5] = '{wr: 1'b0, addr: 32'hFFFF_C23F, d: '0,  exp: dd};
        tv[6] = '{wr: 1'b0, addr: 32'h0000_001F, d: '0,  exp: pat};

        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        z_en = 1'b0; z_wr = 1'b0; z_addr = '0; z_din = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_quiet", {ack, busy, dout}, '0);
        end

        for (int i = 0; i < 7; i++) begin
            do_req(tv[i].wr, tv[i].addr, tv[i].d, rd, lat);
            chk("tbl_latency", lat, LAT + 9);
            chk(tv[i].wr ? "tbl_wr_hold" : "tbl_rd_data", rd, tv[i].wr ? last_rd : tv[i].exp);
            if (!tv[i].wr) last_rd = tv[i].exp;
        end
        m_line[0] = pat;  m_valid[0] = 1'b1;
        m_line[17] = dd;  m_valid[17] = 1'b1;

        // Write-back then allocate with enable held high throughout.
        r1 = rand_line();
        addr = 32'h40; din = r1; wr = 1'b1; en = 1'b1; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ack && lat < 200);
        chk("b2b_first_latency", lat, LAT + 9);
        wr = 1'b0; n = 0;
        do begin @(posedge clk); #1; n++; end while (!ack && n < 200);
        chk("b2b_ack_spacing", n, LAT + 10);
        chk("b2b_read_data", dout, r1);
        en = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle", {ack, busy}, '0);
        m_line[2] = r1; m_valid[2] = 1'b1; last_rd = r1;

        // Zero-latency instance: ack nine cycles after the request is presented.
        zp = rand_line();
        z_addr = 32'h20; z_din = zp; z_wr = 1'b1; z_en = 1'b1; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!z_ack && lat < 200);
        chk("lat0_wr_latency", lat, 9);
        z_en = 1'b0; z_wr = 1'b0;
        @(posedge clk); #1;
        z_addr = 32'h3C; z_en = 1'b1; lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!z_ack && lat < 200);
        chk("lat0_rd_latency", lat, 9);
        chk("lat0_rd_data", z_dout, zp);
        z_en = 1'b0;

        // Reset after the fourth word of a line-5 write has been committed.
        apply(1'b1, 32'hA0, '0);
        addr = 32'hA0; din = {8{32'hAAAA_AAAA}}; wr = 1'b1; en = 1'b1;
        repeat (LAT + 5) @(posedge clk);
        #1 rst_n = 1'b0; en = 1'b0; wr = 1'b0;
        #1;
        chk("rst_ack", {255'd0, ack}, '0);
        chk("rst_busy", {255'd0, busy}, '0);
        chk("rst_data_o", dout, '0);
        n = 0;
        repeat (2) begin @(posedge clk); #1; n += int'(ack); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n += int'(ack);
        chk("rst_no_ack", n, 0);
        chk("rst_release_idle", {255'd0, busy}, '0);
        last_rd = '0;
        m_line[5] = {128'd0, {4{32'hAAAA_AAAA}}};
        apply(1'b0, 32'hA0, '0);

        // Random traffic against the line-level model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic        w;
            int          ln;
            ln = $urandom_range(0, 15);
            a  = ($urandom & 32'hFFFF_C01F) | (32'(ln) << 5);
            w  = !m_valid[ln] || ($urandom_range(0, 1) == 1);
            apply(w, a, rand_line());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
